// File: rtl/axi_dma_w.sv
// axi_dma_w: AXI4 write burst master (AW, len+1 W beats, B); optional bresp check via AXI_DMA_W_BRESP_CHECK_EN
module axi_dma_w #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                ready,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                error,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [LEN_W-1:0]    m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);
    typedef enum logic [1:0] {W_ADDR_HS, W_DATA, W_RESP} state_t;
    state_t state, state_nx;
    logic [LEN_W:0] cnt, cnt_nx;
    logic [LEN_W-1:0] len_r, len_nx;
    logic last;
    logic unused_ok;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = len;
    assign m_axi_awsize  = 3'($clog2(DATA_W/8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = wstrb;
    assign last = cnt == {1'b0, len_r};
    // state, beat counter and latched burst length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= W_ADDR_HS;
            cnt   <= '0;
            len_r <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            len_r <= len_nx;
        end
    end
    // next state and handshake outputs, all forced low while in reset
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        len_nx        = len_r;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        ready         = 1'b0;
        busy          = 1'b0;
        case (state)
            W_ADDR_HS: begin
                m_axi_awvalid = valid;
                if (valid && m_axi_awready) begin
                    state_nx = W_DATA;
                    cnt_nx   = '0;
                    len_nx   = len;
                end
            end
            W_DATA: begin
                m_axi_wvalid = valid;
                ready        = valid && m_axi_wready;
                m_axi_wlast  = last;
                busy         = 1'b1;
                if (valid && m_axi_wready) begin
                    cnt_nx = cnt + 1'b1;
                    if (last) state_nx = W_RESP;
                end
            end
            W_RESP: begin
                m_axi_bready = 1'b1;
                busy         = 1'b1;
                if (m_axi_bvalid) state_nx = W_ADDR_HS;
            end
            default: state_nx = W_ADDR_HS;
        endcase
        if (!rst) begin
            m_axi_awvalid = 1'b0;
            m_axi_wvalid  = 1'b0;
            m_axi_wlast   = 1'b0;
            m_axi_bready  = 1'b0;
            ready         = 1'b0;
            busy          = 1'b0;
        end
    end
`ifdef AXI_DMA_W_BRESP_CHECK_EN
    logic err_r;
    // capture the response status of each accepted B beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_r <= 1'b0;
        else if (state == W_RESP && m_axi_bvalid) err_r <= m_axi_bresp != 2'b00;
    end
    assign error     = err_r;
    assign unused_ok = ^m_axi_bid;
`else
    assign error     = 1'b0;
    assign unused_ok = ^{m_axi_bid, m_axi_bresp};
`endif
endmodule

// File: tb/tb_axi_dma_w.sv
// tb_axi_dma_w: scoreboard bench for axi_dma_w, directed bursts with queued expectations
module tb_axi_dma_w;
    localparam int ADDR_W = 32, DATA_W = 256, LEN_W = 8, ID_W = 1, SW = DATA_W / 8;
    logic clk = 0, rst = 0, valid = 0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic [LEN_W-1:0] len = '0;
    logic ready, busy, error;
    logic [ID_W-1:0] m_axi_awid, m_axi_bid;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [LEN_W-1:0] m_axi_awlen;
    logic [2:0] m_axi_awsize, m_axi_awprot;
    logic [1:0] m_axi_awburst, m_axi_bresp;
    logic m_axi_awlock, m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic [3:0] m_axi_awcache, m_axi_awqos;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;

    axi_dma_w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .len(len), .busy(busy), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    typedef struct {logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l;} aw_t;
    typedef struct {logic [DATA_W-1:0] d; logic [SW-1:0] s; logic last;} w_t;
    aw_t aw_q[$];
    w_t w_q[$];
    logic e_q[$];
    int total = 0, bad = 0;
    int awv_n = 0, rdy_n = 0, wlast_n = 0;
    bit b_pend = 0, done = 0;

    task automatic chk(input string n, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", n);
    endtask

    function automatic logic [DATA_W-1:0] dat(input logic [31:0] a, input int j);
        return {8{a + 32'(j) * 32'h01010101}};
    endfunction

    function automatic logic [SW-1:0] stb(input int j);
        return {4{8'(j) ^ 8'hA5}};
    endfunction

    task automatic monitor();
        aw_t ea;
        w_t ew;
        logic ee;
        while (!done) begin
            @(negedge clk);
            if (b_pend) begin
                b_pend = 0;
                if (e_q.size() == 0) fail("b_unexpected");
                else begin
                    ee = e_q.pop_front();
                    chk("error", error, ee);
                    chk("busy_after_b", busy, 0);
                end
            end
            if (m_axi_awvalid) awv_n++;
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) fail("aw_unexpected");
                else begin
                    ea = aw_q.pop_front();
                    chk("awaddr", m_axi_awaddr, ea.a);
                    chk("awlen", m_axi_awlen, ea.l);
                    chk("awsize", m_axi_awsize, 3'd5);
                    chk("awburst", m_axi_awburst, 2'b01);
                    chk("awcache", m_axi_awcache, 4'h2);
                    chk("awprot", m_axi_awprot, 3'b010);
                    chk("awid", m_axi_awid, 0);
                end
            end
            if (ready) rdy_n++;
            if (m_axi_wvalid && m_axi_wready) begin
                chk("ready_on_accept", ready, 1);
                if (m_axi_wlast) wlast_n++;
                if (w_q.size() == 0) fail("w_unexpected");
                else begin
                    ew = w_q.pop_front();
                    chk("wdata", m_axi_wdata, ew.d);
                    chk("wstrb", m_axi_wstrb, ew.s);
                    chk("wlast", m_axi_wlast, ew.last);
                end
            end
            if (m_axi_bvalid && m_axi_bready) b_pend = 1;
        end
    endtask

    task automatic burst(input logic [31:0] a, input int l, input int aw_wait, input bit alt,
                         input int new_len, input int rst_beat, input int bdelay, input logic [1:0] br);
        int aw0, r0, wl0, i, cyc;
        bit hs;
        aw0 = awv_n; r0 = rdy_n; wl0 = wlast_n; i = 0; cyc = 0;
        addr = a; len = LEN_W'(l); valid = 1; wdata = dat(a, 0); wstrb = stb(0);
        m_axi_awready = 0; m_axi_wready = 0;
        for (int k = 0; k < aw_wait; k++) begin
            @(negedge clk);
            chk("awvalid_wait", m_axi_awvalid, 1);
            chk("awaddr_stable", m_axi_awaddr, a);
            chk("wvalid_in_aw", m_axi_wvalid, 0);
            chk("busy_in_aw", busy, 0);
            @(posedge clk); #1;
        end
        aw_q.push_back('{a, LEN_W'(l)});
        for (int j = 0; j <= l; j++) w_q.push_back('{dat(a, j), stb(j), j == l});
        m_axi_awready = 1;
        @(posedge clk); #1;
        m_axi_awready = 0;
        if (new_len >= 0) len = LEN_W'(new_len);
        while (i <= l && cyc < 2000) begin
            if (i == rst_beat) begin
                rst = 0;
                #1;
                chk("rst_awvalid", m_axi_awvalid, 0);
                chk("rst_wvalid", m_axi_wvalid, 0);
                chk("rst_ready", ready, 0);
                chk("rst_wlast", m_axi_wlast, 0);
                chk("rst_bready", m_axi_bready, 0);
                chk("rst_busy", busy, 0);
                chk("beats_before_rst", rdy_n - r0, rst_beat);
                w_q.delete();
                valid = 0; m_axi_wready = 0;
                repeat (2) begin @(posedge clk); #1; end
                rst = 1;
                @(negedge clk);
                chk("post_rst_busy", busy, 0);
                chk("post_rst_awvalid", m_axi_awvalid, 0);
                @(posedge clk); #1;
                return;
            end
            wdata = dat(a, i); wstrb = stb(i);
            m_axi_wready = alt ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            hs = ready;
            @(posedge clk); #1;
            if (hs) i++;
            cyc++;
        end
        if (i <= l) fail("w_timeout");
        valid = 0; m_axi_wready = 0;
        chk("ready_pulses", rdy_n - r0, l + 1);
        chk("wlast_count", wlast_n - wl0, 1);
        chk("awvalid_cycles", awv_n - aw0, aw_wait + 1);
`ifdef AXI_DMA_W_BRESP_CHECK_EN
        e_q.push_back(br != 2'b00);
`else
        e_q.push_back(1'b0);
`endif
        for (int k = 0; k < bdelay; k++) begin
            @(negedge clk);
            chk("bready_wait", m_axi_bready, 1);
            chk("busy_in_b", busy, 1);
            chk("wvalid_in_b", m_axi_wvalid, 0);
            @(posedge clk); #1;
        end
        m_axi_bvalid = 1; m_axi_bresp = br;
        @(posedge clk); #1;
        m_axi_bvalid = 0; m_axi_bresp = 0;
        @(posedge clk); #1;
        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        chk("e_q_empty", e_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
        fork
            monitor();
            begin
                valid = 1;
                #12;
                chk("reset_awvalid", m_axi_awvalid, 0);
                chk("reset_busy", busy, 0);
                chk("reset_error", error, 0);
                chk("reset_ready", ready, 0);
                valid = 0;
                @(posedge clk); #1;
                rst = 1;
                @(posedge clk); #1;
                burst(32'h100, 0, 0, 0, -1, -1, 2, 2'b00);
                burst(32'h2000, 3, 0, 1, -1, -1, 1, 2'b00);
                burst(32'h3000, 1, 5, 0, -1, -1, 0, 2'b00);
                burst(32'h4000, 7, 0, 0, 2, -1, 1, 2'b00);
                burst(32'h5000, 1, 0, 0, -1, -1, 0, 2'b10);
                burst(32'h5100, 0, 0, 0, -1, -1, 0, 2'b00);
                burst(32'h6000, 3, 0, 0, -1, 1, 0, 2'b00);
                burst(32'h7000, 3, 1, 1, -1, -1, 1, 2'b11);
                burst(32'h8000, 255, 0, 0, -1, -1, 0, 2'b00);
                done = 1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_dma_w.md
Name: axi_dma_w

Overview:
AXI4 write-channel burst master for the DMA. It is the write-side counterpart of the DMA read engine.
- Accepts a native databus write request (valid/addr/wdata/wstrb) plus a configured burst length.
- Issues one AW handshake, streams len+1 W beats from the databus, then collects the B response.
- Sits between the accelerator-side databus and the MIG AXI slave port.

Parameters:
ADDR_W, 32, DDR byte address width (awaddr, addr)
DATA_W, 256, MIG data bus width; awsize = log2(DATA_W/8)
LEN_W, 8, AXI burst length width
ID_W, 1, AXI ID width

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
valid  input  1  databus request / beat valid
addr  input  ADDR_W  burst start address, sampled at AW handshake
wdata  input  DATA_W  beat data
wstrb  input  DATA_W/8  beat byte strobes
ready  output  1  pulses once per accepted W beat
len  input  LEN_W  beats per burst minus one
busy  output  1  high from AW accept until B accepted
error  output  1  sticky-per-burst write response error
m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  output  AXI widths  AW payload
m_axi_awvalid  output  1; m_axi_awready  input  1
m_axi_wdata  output  DATA_W; m_axi_wstrb  output  DATA_W/8; m_axi_wlast  output  1; m_axi_wvalid  output  1; m_axi_wready  input  1
m_axi_bid  input  ID_W; m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1

Behaviour:
- Constant outputs:
  - awid=0, awburst=INCR (01), awlock=0, awcache=4'h2, awprot=3'b010, awqos=0, awsize=log2(DATA_W/8).
  - awaddr=addr; awlen=len; wdata=wdata; wstrb=wstrb.
- Registers:
  - state (W_ADDR_HS, W_DATA, W_RESP).
  - beat counter, LEN_W+1 bits.
  - len_r, LEN_W bits.
  - error.
- Reset: state=W_ADDR_HS, counter=0, len_r=0, error=0. All valid/ready/last/busy outputs are 0 while rst is low. Reset asserted mid-burst aborts immediately to W_ADDR_HS, with no further AXI signalling.
- W_ADDR_HS:
  - awvalid=valid.
  - On valid&&awready: len_r<=len, counter<=0, go to W_DATA.
  - ready=0, wvalid=0, bready=0, busy=0.
- W_DATA:
  - wvalid=valid, ready=valid&&wready, wlast=(counter==len_r), busy=1.
  - Each accept (valid&&wready) increments the counter.
  - An accept with counter==len_r goes to W_RESP.
  - valid low inserts bubbles (wvalid low); no data is dropped.
- W_RESP:
  - bready=1, busy=1, wvalid=0, ready=0.
  - On bvalid: error<=(bresp!=2'b00), go to W_ADDR_HS.
- error holds its value until the next B accept overwrites it.
- len changes after the AW handshake are ignored; len_r governs wlast and the beat count.
- len=0: single beat, wlast=1 on the first W cycle.
- len=2^LEN_W-1: counter reaches 2^LEN_W-1 without overflow (LEN_W+1 bits).
- awvalid, once raised, stays high only while valid stays high. The databus keeps valid asserted until ready; this is a databus rule, not checked here.
- Latencies:
  - AW handshake to first possible W accept: 1 cycle.
  - Last W accept to bready: 1 cycle.
  - bvalid to next awvalid: 1 cycle.

Optional Feature:
AXI_DMA_W_BRESP_CHECK_EN:
- Defined: error behaves as above.
- Undefined: error is tied to 0, bresp is ignored, and the error register is not synthesized. The FSM is unchanged.

Test Plan:
1. len=0, addr=0x100, valid held, awready=1, wready=1, bvalid after 2 cycles with bresp=00 -> exactly one awvalid cycle (awlen=0); one W beat with wlast=1 and ready=1; bready high until bvalid; error=0; busy drops the cycle after the B accept.
2. len=3, wready low on alternate cycles -> 4 accepted beats in order; ready pulses 4 times; wlast only on beat 4; counter=3 at wlast.
3. awready held low 5 cycles -> awvalid stays 1 with awaddr stable; no wvalid; state remains W_ADDR_HS until the awready cycle.
4. len=7; change len to 2 after AW accept -> still 8 beats; wlast on beat 8; awlen=7.
5. bresp=2'b10 on B -> error=1 with the macro, 0 without. A following burst with bresp=00 returns error to 0.
6. Assert rst low on beat 2 of len=3 -> all outputs 0 within the same cycle. After release: state W_ADDR_HS, counter 0, and a new burst proceeds normally.
